uart_xmit_arbiter: RTL and testbench

- Round-robin arbiter that shares one UART transmitter (u_xmit) between NUM_REQ byte producers.
- Latches the winning requester's byte and issues a one-cycle xmitH with stable xmit_dataH.
- Waits for the transmitter's done indication, then enforces a programmable inter-frame gap before the next grant.
- Sits between client logic and u_xmit inside the UART top level.

---
 rtl/uart_xmit_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_uart_xmit_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_xmit_arbiter.sv
// ---------------------------------------------------------------------------
// uart_xmit_arbiter
//
// Purpose:
//   Shares one UART transmitter between NUM_REQ byte producers using
//   round-robin arbitration. The winner's byte is latched and held on
//   xmit_dataH. A one-cycle xmitH start pulse follows. The arbiter then waits
//   for xmit_doneH, or gives up after TIMEOUT_CYCLES. Finally it idles for
//   GAP_CYCLES before the next grant.
//
// Ports:
//   sys_clk      in   system clock
//   sys_rst      in   synchronous active-high reset
//   req          in   per-requester level request, held until acknowledged
//   req_data     in   byte for requester i on bits [8i+7:8i]
//   req_ack      out  one-cycle pulse, the requester's byte has been latched
//   xmitH        out  one-cycle start pulse to the transmitter
//   xmit_dataH   out  byte to the transmitter, held for the whole frame
//   xmit_doneH   in   transmitter completion (pulse or level)
//   busy         out  high whenever the arbiter is not idle
//   owner        out  index of the current or most recent grantee
//   timeout_err  out  one-cycle pulse when a frame is aborted on timeout
//
// All outputs are registered. Each one shows the action taken in a state
// during the following cycle. So req_ack is seen in the LOAD cycle, and
// xmitH is seen in the first WAIT_DONE cycle, two cycles after the ack.
// ---------------------------------------------------------------------------
module uart_xmit_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic                 xmitH,
   output logic [7:0]           xmit_dataH,
   input  logic                 xmit_doneH,
   output logic                 busy,
   output logic [2:0]           owner,
   output logic                 timeout_err
);

   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   // A zero-length gap never enters GAP, but the counter still needs one bit.
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   // The counter is 0 in the xmitH cycle. The transition taken while it reads
   // TIMEOUT_CYCLES-1 therefore lands the error pulse TIMEOUT_CYCLES after xmitH.
   localparam logic [TO_W-1:0]  TO_FIRE  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_MAX   = {TO_W{1'b1}};
   // Done is honoured from the third WAIT_DONE cycle (count 2). A stale idle
   // level from the transmitter is not mistaken for completion.
   localparam logic [TO_W-1:0]  DONE_MIN = TO_W'(2);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [2:0]       LAST_IDX = 3'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ISSUE,
      WAIT_DONE,
      GAP
   } state_t;

   state_t             r_state;
   logic [2:0]         r_rrPtr;
   logic [2:0]         r_owner;
   logic [7:0]         r_data;
   logic [NUM_REQ-1:0] r_ack;
   logic               r_xmit;
   logic               r_busy;
   logic               r_timeoutErr;
   logic [TO_W-1:0]    r_toCnt;
   logic [GAP_W-1:0]   r_gapCnt;

   logic               w_grantValid;
   logic [2:0]         w_grantIdx;
   logic [8*NUM_REQ-1:0] w_dataSh;
   logic [7:0]         w_grantData;
   logic               w_doneSeen;
   logic               w_timedOut;

   // Returns bit idx of a request vector. A shift is used instead of a
   // variable index, which keeps index widths independent of NUM_REQ.
   function automatic logic reqBit(input logic [NUM_REQ-1:0] vec, input int idx);
      logic [NUM_REQ-1:0] sh;
      sh = vec >> idx;
      return sh[0];
   endfunction

   // Round-robin pick. The scan runs from the farthest offset back toward the
   // pointer, so the set bit nearest the pointer (wrapping) wins.
   always_comb begin
      w_grantValid = 1'b0;
      w_grantIdx   = 3'd0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         int idx;
         idx = int'(r_rrPtr) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (reqBit(req, idx)) begin
            w_grantValid = 1'b1;
            w_grantIdx   = 3'(idx);
         end
      end
   end

   // Selects the winning requester's byte and decodes the end-of-frame
   // conditions used in WAIT_DONE.
   always_comb begin
      w_dataSh    = req_data >> {w_grantIdx, 3'b000};
      w_grantData = w_dataSh[7:0];
      w_doneSeen  = xmit_doneH && (r_toCnt >= DONE_MIN);
      w_timedOut  = (r_toCnt >= TO_FIRE);
   end

   // Main control FSM. Every output is a register written here. Pulse
   // outputs default low each cycle and are raised only by the state that
   // owns them.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state      <= IDLE;
         r_rrPtr      <= 3'd0;
         r_owner      <= 3'd0;
         r_data       <= 8'd0;
         r_ack        <= '0;
         r_xmit       <= 1'b0;
         r_busy       <= 1'b0;
         r_timeoutErr <= 1'b0;
         r_toCnt      <= '0;
         r_gapCnt     <= '0;
      end else begin
         r_ack        <= '0;
         r_xmit       <= 1'b0;
         r_timeoutErr <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grantValid) begin
                  r_owner <= w_grantIdx;
                  r_data  <= w_grantData;
                  r_ack   <= NUM_REQ'(1) << w_grantIdx;
                  r_busy  <= 1'b1;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               r_state <= ISSUE;
            end
            ISSUE: begin
               r_xmit  <= 1'b1;
               r_toCnt <= '0;
               r_state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (r_toCnt != TO_MAX) r_toCnt <= r_toCnt + 1'b1;
               if (w_doneSeen || w_timedOut) begin
                  // A real completion takes precedence over a timeout that
                  // expires in the same cycle.
                  r_timeoutErr <= !w_doneSeen;
                  r_rrPtr      <= (r_owner == LAST_IDX) ? 3'd0 : r_owner + 3'd1;
                  r_gapCnt     <= '0;
                  if (GAP_CYCLES == 0) begin
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     r_state <= GAP;
                  end
               end
            end
            GAP: begin
               if (r_gapCnt == GAP_LAST) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_gapCnt <= r_gapCnt + 1'b1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign req_ack     = r_ack;
   assign xmitH       = r_xmit;
   assign xmit_dataH  = r_data;
   assign busy        = r_busy;
   assign owner       = r_owner;
   assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_uart_xmit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_xmit_arbiter
//
// Scoreboard bench for uart_xmit_arbiter.
// - Producers hold per-requester byte queues and keep req high while bytes
//   remain.
// - A reference model turns each batch of bytes into the expected
//   (owner, byte) transmit order using the round-robin rule.
// - A done model answers each xmitH. It predicts when busy falls and when
//   timeout_err fires.
// - A monitor compares everything the DUT presents against those queues.
// ---------------------------------------------------------------------------
module tb_uart_xmit_arbiter;

   localparam int NUM_REQ = 4;
   localparam int GAP     = 16;
   localparam int TMO     = 64;

   logic                 sys_clk = 1'b0;
   logic                 sys_rst;
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ack;
   logic                 xmitH;
   logic [7:0]           xmit_dataH;
   logic                 xmit_doneH;
   logic                 busy;
   logic [2:0]           owner;
   logic                 timeout_err;

   uart_xmit_arbiter #(
      .NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .req_data(req_data),
      .req_ack(req_ack), .xmitH(xmitH), .xmit_dataH(xmit_dataH),
      .xmit_doneH(xmit_doneH), .busy(busy), .owner(owner),
      .timeout_err(timeout_err)
   );

   always #5 sys_clk = ~sys_clk;

   // Cycle index. Inside cycle k (after posedge k) cyc reads k.
   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int compared = 0;
   int failed   = 0;

   logic [7:0]  prodQ[NUM_REQ][$];
   logic [10:0] expQ[$];
   int          fallQ[$];
   int          errQ[$];
   int          modelPtr  = 0;
   int          doneMode  = 0;
   int          doneFixed = 0;
   int          phCnt[NUM_REQ];
   logic [7:0]  phByte[NUM_REQ][4];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit allEmpty();
      for (int i = 0; i < NUM_REQ; i++) if (prodQ[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Reference model. It grants the first requester with bytes left, scanning
   // up from the pointer. The pointer then moves just past that requester.
   // The predicted order goes to the scoreboard and the bytes go to the
   // producers.
   task automatic applyStimulus();
      int left[NUM_REQ];
      int taken[NUM_REQ];
      int total;
      total = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         left[i]  = phCnt[i];
         taken[i] = 0;
         total   += phCnt[i];
      end
      while (total > 0) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (modelPtr + k) % NUM_REQ;
            if (left[i] > 0) begin
               expQ.push_back({3'(i), phByte[i][taken[i]]});
               taken[i]++;
               left[i]--;
               total--;
               modelPtr = (i + 1) % NUM_REQ;
               break;
            end
         end
      end
      for (int i = 0; i < NUM_REQ; i++)
         for (int j = 0; j < phCnt[i]; j++) prodQ[i].push_back(phByte[i][j]);
   endtask

   task automatic waitDrain(input int limit);
      int n;
      n = 0;
      while (n < limit && !(allEmpty() && busy == 1'b0 && expQ.size() == 0)) begin
         @(negedge sys_clk);
         n++;
      end
      checkOutput("drain within budget", 32'(n < limit), 32'd1);
      repeat (2) @(negedge sys_clk);
   endtask

   // Producers. After an ack each one pops its byte, then presents the next
   // byte or random junk. Junk shows that late data changes cannot reach the
   // frame in flight.
   initial begin
      logic [7:0] dummy;
      req      = '0;
      req_data = '0;
      forever begin
         @(posedge sys_clk);
         #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ack[i] && prodQ[i].size() > 0) dummy = prodQ[i].pop_front();
            if (prodQ[i].size() > 0) begin
               req[i]           = 1'b1;
               req_data[8*i +: 8] = prodQ[i][0];
            end else begin
               req[i]           = 1'b0;
               req_data[8*i +: 8] = 8'($urandom);
            end
         end
      end
   end

   // Transmitter done model.
   //   Mode 0: normal pulse after 2..40 cycles, or after doneFixed if set.
   //   Mode 1: stale level, then a real pulse at +50.
   //   Mode 2: never completes.
   //   Mode 3: frame is killed by reset.
   // busy must fall GAP cycles after the frame leaves WAIT_DONE.
   initial begin
      int t, d, mode;
      xmit_doneH = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (xmitH === 1'b1 && sys_rst === 1'b0) begin
            t        = cyc;
            mode     = doneMode;
            doneMode = 0;
            case (mode)
               0: begin
                  d = (doneFixed > 0) ? doneFixed : int'($urandom_range(2, 40));
                  fallQ.push_back(t + d + 1 + GAP);
                  repeat (d) @(posedge sys_clk);
                  #1 xmit_doneH = 1'b1;
                  @(posedge sys_clk);
                  #1 xmit_doneH = 1'b0;
               end
               1: begin
                  fallQ.push_back(t + 50 + 1 + GAP);
                  xmit_doneH = 1'b1;
                  repeat (2) @(posedge sys_clk);
                  #1 xmit_doneH = 1'b0;
                  repeat (48) @(posedge sys_clk);
                  #1 xmit_doneH = 1'b1;
                  @(posedge sys_clk);
                  #1 xmit_doneH = 1'b0;
               end
               2: begin
                  errQ.push_back(t + TMO);
                  fallQ.push_back(t + TMO + GAP);
               end
               default: ;
            endcase
         end
      end
   end

   // Monitor. It compares each start pulse against the scoreboard and checks
   // ack/xmit spacing, one-hot acks and data hold. It also checks every
   // timeout pulse and busy fall against the done model's predictions.
   initial begin
      logic [10:0] e;
      logic [7:0]  holdByte;
      bit          holding, prevBusy, prevXmit;
      int          lastAck;
      holding = 0; prevBusy = 0; prevXmit = 0; lastAck = -100; holdByte = 8'd0;
      forever begin
         @(negedge sys_clk);
         if (sys_rst === 1'b1) begin
            holding  = 0;
            prevBusy = 0;
            prevXmit = 0;
         end else begin
            if (req_ack != '0) begin
               checkOutput("req_ack one-hot", 32'($countones(req_ack)), 32'd1);
               lastAck = cyc;
            end
            if (xmitH === 1'b1) begin
               checkOutput("xmitH single cycle", 32'(prevXmit), 32'd0);
               checkOutput("xmitH two cycles after ack", 32'(cyc - lastAck), 32'd2);
               if (expQ.size() == 0) begin
                  checkOutput("unexpected frame owner", 32'(owner), 32'h7ff);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("frame owner", 32'(owner), 32'(e[10:8]));
                  checkOutput("frame byte", 32'(xmit_dataH), 32'(e[7:0]));
                  holdByte = e[7:0];
                  holding  = 1;
               end
            end else if (holding) begin
               checkOutput("xmit_dataH held", 32'(xmit_dataH), 32'(holdByte));
            end
            if (timeout_err === 1'b1) begin
               if (errQ.size() == 0) checkOutput("unexpected timeout_err cycle", 32'(cyc), 32'hffff_ffff);
               else checkOutput("timeout_err cycle", 32'(cyc), 32'(errQ.pop_front()));
            end
            if (prevBusy && busy === 1'b0) begin
               if (fallQ.size() == 0) checkOutput("unexpected busy fall cycle", 32'(cyc), 32'hffff_ffff);
               else checkOutput("busy fall cycle", 32'(cyc), 32'(fallQ.pop_front()));
               holding = 0;
            end
            prevBusy = (busy === 1'b1);
            prevXmit = (xmitH === 1'b1);
         end
      end
   end

   initial begin
      int n0, n;
      sys_rst = 1'b1;

      // Reset with all four requesting: outputs stay quiet. After release
      // the model, whose pointer starts at 0, expects requester 0 first.
      $display("[TB] reset check");
      for (int i = 0; i < NUM_REQ; i++) begin
         phCnt[i]     = 1;
         phByte[i][0] = 8'($urandom);
      end
      applyStimulus();
      for (int k = 0; k < 3; k++) begin
         @(negedge sys_clk);
         checkOutput("reset xmitH", 32'(xmitH), 32'd0);
         checkOutput("reset req_ack", 32'(req_ack), 32'd0);
         checkOutput("reset busy", 32'(busy), 32'd0);
         checkOutput("reset owner", 32'(owner), 32'd0);
      end
      @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      waitDrain(2000);

      // Single requester: ack one cycle after req; data and gap timing are
      // checked by the monitor.
      $display("[TB] single requester");
      doneFixed = 40;
      phCnt = '{0, 0, 1, 0};
      phByte[2][0] = 8'hA5;
      @(negedge sys_clk);
      n0 = cyc;
      applyStimulus();
      n = 0;
      while (n < 20 && req_ack[2] !== 1'b1) begin
         @(negedge sys_clk);
         n++;
      end
      checkOutput("ack latency", 32'(cyc - n0), 32'd2);
      waitDrain(2000);
      doneFixed = 0;

      // Round robin: all requesters hold req for two bytes each.
      $display("[TB] round robin");
      for (int i = 0; i < NUM_REQ; i++) begin
         phCnt[i]     = 2;
         phByte[i][0] = 8'h10 + 8'(17 * i);
         phByte[i][1] = 8'h10 + 8'(17 * i);
      end
      applyStimulus();
      waitDrain(4000);

      // Random batches.
      for (int p = 0; p < 6; p++) begin
         $display("[TB] random batch %0d", p);
         for (int i = 0; i < NUM_REQ; i++) begin
            phCnt[i] = int'($urandom_range(0, 3));
            for (int j = 0; j < 4; j++) phByte[i][j] = 8'($urandom);
         end
         if (phCnt[0] + phCnt[1] + phCnt[2] + phCnt[3] == 0) phCnt[$urandom_range(0, 3)] = 1;
         applyStimulus();
         waitDrain(4000);
      end

      // Stale done level right after xmitH must not end the frame.
      $display("[TB] stale done");
      doneMode = 1;
      phCnt = '{0, 1, 0, 0};
      phByte[1][0] = 8'h5A;
      applyStimulus();
      waitDrain(2000);

      // Timeout on the first frame, then a normal frame for the other requester.
      $display("[TB] timeout");
      doneMode = 2;
      phCnt = '{1, 0, 0, 1};
      phByte[0][0] = 8'hC3;
      phByte[3][0] = 8'h3C;
      applyStimulus();
      waitDrain(2000);

      // Reset while in WAIT_DONE: everything clears and the pointer returns
      // to 0, so requesters 1 and 3 are then served 1 first.
      $display("[TB] reset mid-frame");
      doneMode = 3;
      phCnt = '{0, 1, 0, 0};
      phByte[1][0] = 8'h77;
      applyStimulus();
      n = 0;
      while (n < 100 && xmitH !== 1'b1) begin
         @(negedge sys_clk);
         n++;
      end
      checkOutput("mid-frame xmitH seen", 32'(n < 100), 32'd1);
      repeat (5) @(posedge sys_clk);
      #1 sys_rst = 1'b1;
      @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      @(negedge sys_clk);
      checkOutput("post-reset busy", 32'(busy), 32'd0);
      checkOutput("post-reset owner", 32'(owner), 32'd0);
      checkOutput("post-reset xmitH", 32'(xmitH), 32'd0);
      modelPtr = 0;
      repeat (80) @(negedge sys_clk);
      phCnt = '{0, 1, 0, 1};
      phByte[1][0] = 8'h11;
      phByte[3][0] = 8'h33;
      applyStimulus();
      waitDrain(2000);

      checkOutput("frames left in scoreboard", 32'(expQ.size()), 32'd0);
      checkOutput("busy falls left", 32'(fallQ.size()), 32'd0);
      checkOutput("timeouts left", 32'(errQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
